// File: rtl/risc_v_cpu_multicycle.sv
// Multi-cycle RV32I core (integer base subset: ALU reg/imm, lui, auipc, jal,
// jalr, branches, lw, sw). Every instruction is sequenced FETCH -> EXEC ->
// [MEM] -> WB by one FSM. Both memories sit behind req/ready handshakes so
// wait-state memories work; an optional bus timeout parks the core in FAULT.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   imem_req/addr            fetch request and address (current PC)
//   imem_ready/rdata         fetch completion and fetched instruction
//   dmem_req/we/addr/wdata   data request, store enable, address, store data
//   dmem_ready/rdata         data completion and load data
//   out                      last value presented to the register file
//   retire                   one-cycle pulse per retired instruction
//   instret                  retired-instruction count (wraps)
//   fault                    sticky bus-timeout flag
module risc_v_cpu_multicycle #(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [31:0]          dmem_rdata,
    output logic [31:0]          out,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instret,
    output logic                 fault
);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_EQ, ALU_PASSB
    } alu_op_t;

    state_t       state;
    logic [31:0]  pc, ir, wait_cnt;
    logic         dmem_we_q;
    logic [31:0]  alu_q, opb_q, next_pc_q, rdata_q;
    logic [31:0]  rf [32];

    logic [6:0]   opcode;
    logic [2:0]   f3;
    logic [4:0]   rd, rs1, rs2;
    logic signed [31:0] imm, rs1_val, rs2_val, opa, opb;
    alu_op_t      alu_op;
    logic         alu_src_imm, alu_not, is_branch, mem_we, reg_we;
    logic [1:0]   pc_is_branch, reg_sel_data_in, pc_sel;
    logic [31:0]  alu_res, npc, pc_plus4, wb_data;
    logic         timeout_hit;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    assign rs1_val  = (rs1 == 5'd0) ? 32'sd0 : $signed(rf[rs1]);
    assign rs2_val  = (rs2 == 5'd0) ? 32'sd0 : $signed(rf[rs2]);
    assign opa      = rs1_val;
    assign opb      = alu_src_imm ? imm : rs2_val;
    assign pc_plus4 = pc + 32'd4;

    assign imem_addr  = pc;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = opb_q;
    // A store caught by reset must not reach memory in the reset cycle.
    assign dmem_we    = dmem_we_q & ~reset;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1);

    // Decoder: purely a function of IR, so it stays valid through MEM and WB.
    always_comb begin
        imm             = $signed({{20{ir[31]}}, ir[31:20]});
        alu_op          = ALU_ADD;
        alu_src_imm     = 1'b0;
        alu_not         = 1'b0;
        is_branch       = 1'b0;
        pc_is_branch    = 2'd0;
        mem_we          = 1'b0;
        reg_we          = 1'b0;
        reg_sel_data_in = 2'd0;
        case (opcode)
            7'b0010011, 7'b0110011: begin
                alu_src_imm = ~opcode[5];
                reg_we      = 1'b1;
                case (f3)
                    3'b000:  alu_op = (opcode[5] && ir[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = ir[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            7'b0110111, 7'b0010111: begin
                imm             = $signed({ir[31:12], 12'b0});
                alu_src_imm     = 1'b1;
                alu_op          = ALU_PASSB;
                reg_we          = 1'b1;
                reg_sel_data_in = opcode[5] ? 2'd0 : 2'd3;
            end
            7'b1101111: begin
                imm             = $signed({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
                pc_is_branch    = 2'd1;
                reg_we          = 1'b1;
                reg_sel_data_in = 2'd2;
            end
            7'b1100111: begin
                alu_src_imm     = 1'b1;
                pc_is_branch    = 2'd2;
                reg_we          = 1'b1;
                reg_sel_data_in = 2'd2;
            end
            7'b1100011: begin
                imm       = $signed({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
                is_branch = (f3[2:1] != 2'b01);
                alu_not   = f3[0];
                case (f3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_EQ;
                endcase
            end
            7'b0000011: begin
                alu_src_imm     = 1'b1;
                reg_we          = 1'b1;
                reg_sel_data_in = 2'd1;
            end
            7'b0100011: begin
                imm         = $signed({{20{ir[31]}}, ir[31:25], ir[11:7]});
                alu_src_imm = 1'b1;
                mem_we      = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU: compare ops return 0/1 so bit 1 is clear for branch pc_sel.
    always_comb begin
        case (alu_op)
            ALU_SUB:   alu_res = opa - opb;
            ALU_SLL:   alu_res = opa << opb[4:0];
            ALU_SLT:   alu_res = {31'b0, opa < opb};
            ALU_SLTU:  alu_res = {31'b0, $unsigned(opa) < $unsigned(opb)};
            ALU_XOR:   alu_res = opa ^ opb;
            ALU_SRL:   alu_res = $unsigned(opa) >> opb[4:0];
            ALU_SRA:   alu_res = $unsigned(opa >>> opb[4:0]);
            ALU_OR:    alu_res = opa | opb;
            ALU_AND:   alu_res = opa & opb;
            ALU_EQ:    alu_res = {31'b0, opa == opb};
            ALU_PASSB: alu_res = opb;
            default:   alu_res = opa + opb;
        endcase
    end

    always_comb begin
        pc_sel = is_branch ? {alu_res[1], alu_res[0] ^ alu_not} : pc_is_branch;
        case (pc_sel)
            2'd0:    npc = pc_plus4;
            2'd1:    npc = pc + $unsigned(imm);
            2'd2:    npc = alu_res;
            default: npc = RESET_ADDR;
        endcase
        case (reg_sel_data_in)
            2'd0:    wb_data = alu_q;
            2'd1:    wb_data = rdata_q;
            2'd2:    wb_data = pc_plus4;
            default: wb_data = pc + alu_q;
        endcase
    end

    // Datapath latches and register file; x0 is never written.
    always_ff @(posedge clock) begin
        if (state == S_EXEC) begin
            alu_q     <= alu_res;
            opb_q     <= $unsigned(rs2_val);
            next_pc_q <= npc;
        end
        if (state == S_MEM && dmem_ready)
            rdata_q <= dmem_rdata;
        if (!reset && state == S_WB && reg_we && rd != 5'd0)
            rf[rd] <= wb_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_ADDR;
            ir        <= 32'd0;
            out       <= 32'd0;
            instret   <= '0;
            retire    <= 1'b0;
            fault     <= 1'b0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we_q <= 1'b0;
            wait_cnt  <= 32'd0;
        end else begin
            retire <= 1'b0;
            case (state)
                // FETCH: the first cycle after reset only raises the request.
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        wait_cnt <= 32'd0;
                        state    <= S_EXEC;
                    end else if (timeout_hit) begin
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                // EXEC: decode/ALU on IR; loads and stores go to MEM.
                S_EXEC: begin
                    if (mem_we || reg_sel_data_in == 2'd1) begin
                        dmem_req  <= 1'b1;
                        dmem_we_q <= mem_we;
                        state     <= S_MEM;
                    end else begin
                        retire <= 1'b1;
                        state  <= S_WB;
                    end
                end
                // MEM: request held with stable outputs until the handshake.
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req  <= 1'b0;
                        dmem_we_q <= 1'b0;
                        wait_cnt  <= 32'd0;
                        retire    <= 1'b1;
                        state     <= S_WB;
                    end else if (timeout_hit) begin
                        fault     <= 1'b1;
                        dmem_req  <= 1'b0;
                        dmem_we_q <= 1'b0;
                        state     <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                // WB: commit, advance PC and issue the next fetch.
                S_WB: begin
                    if (reg_we)
                        out <= wb_data;
                    pc       <= next_pc_q;
                    instret  <= instret + CNT_WIDTH'(1);
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_v_cpu_multicycle.sv
// Self-checking bench for risc_v_cpu_multicycle. dut1 (no timeout) runs small
// programs from a wait-state memory model; a scoreboard holds the expected
// out/instret/next-PC/latency per retirement. dut2 (timeout 4) checks fault
// behaviour and ready-vs-timeout priority.
module tb_risc_v_cpu_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic        imem_req1, imem_ready1, dmem_req1, dmem_we1, dmem_ready1, retire1, fault1;
    logic [31:0] imem_addr1, imem_rdata1, dmem_addr1, dmem_wdata1, dmem_rdata1, out1, instret1;
    logic        imem_req2, imem_ready2, dmem_req2, dmem_we2, retire2, fault2;
    logic [31:0] imem_addr2, dmem_addr2, dmem_wdata2, out2, instret2;

    logic [31:0] imem [32];
    logic [31:0] dmem [32];
    logic [31:0] load_word, imem_limit;
    int          imem_wait, dmem_wait, icnt, dcnt, wcnt2;
    int          dmem_writes = 0;
    int          dreq_cycles = 0;
    logic        ready2_en;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] out;
        logic [31:0] instret;
        logic [31:0] pc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    risc_v_cpu_multicycle #(.TIMEOUT_CYCLES(0)) dut1 (
        .clock(clk), .reset(rst),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ready(imem_ready1), .imem_rdata(imem_rdata1),
        .dmem_req(dmem_req1), .dmem_we(dmem_we1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
        .dmem_ready(dmem_ready1), .dmem_rdata(dmem_rdata1),
        .out(out1), .retire(retire1), .instret(instret1), .fault(fault1)
    );

    risc_v_cpu_multicycle #(.TIMEOUT_CYCLES(4)) dut2 (
        .clock(clk), .reset(rst2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2), .imem_rdata(32'h0050_0093),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ready(1'b1), .dmem_rdata(32'd0),
        .out(out2), .retire(retire2), .instret(instret2), .fault(fault2)
    );

    assign imem_rdata1 = imem[imem_addr1[6:2]];
    assign imem_ready1 = imem_req1 && (icnt >= imem_wait) && (imem_addr1 < imem_limit);
    assign dmem_rdata1 = dmem[dmem_addr1[6:2]];
    assign dmem_ready1 = dmem_req1 && (dcnt >= dmem_wait);
    assign imem_ready2 = imem_req2 && ready2_en && (wcnt2 == 3);

    always @(posedge clk) begin
        if (rst) begin
            dmem[1] <= load_word;
            icnt    <= 0;
            dcnt    <= 0;
        end else begin
            icnt <= (imem_req1 && !imem_ready1) ? icnt + 1 : 0;
            dcnt <= (dmem_req1 && !dmem_ready1) ? dcnt + 1 : 0;
            if (dmem_req1 && dmem_ready1 && dmem_we1) begin
                dmem[dmem_addr1[6:2]] <= dmem_wdata1;
                dmem_writes           <= dmem_writes + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst2) wcnt2 <= 0;
        else      wcnt2 <= (imem_req2 && !imem_ready2) ? wcnt2 + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] o, input logic [31:0] n, input logic [31:0] p, input int l);
        exp_t e;
        e.out = o; e.instret = n; e.pc = p; e.lat = l;
        sb.push_back(e);
    endtask

    // Pops one expectation per retire; out/instret/next PC are compared on
    // the following negedge, once WB has committed.
    task automatic monitor();
        int          cyc = 0;
        int          start = 0;
        bit          pend = 0;
        logic        prev_ireq = 1'b0;
        logic        prev_dreq = 1'b0;
        logic        pwe = 1'b0;
        logic [31:0] pa = '0;
        logic [31:0] pw = '0;
        exp_t        cur;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend = 0; prev_ireq = 1'b0; prev_dreq = 1'b0; dreq_cycles = 0;
            end else begin
                if (pend) begin
                    check("out", out1, cur.out);
                    check("instret", instret1, cur.instret);
                    check("next_pc", imem_addr1, cur.pc);
                    pend = 0;
                end
                if (imem_req1 && !prev_ireq) start = cyc;
                prev_ireq = imem_req1;
                if (dmem_req1) begin
                    dreq_cycles++;
                    if (prev_dreq) begin
                        check("dmem_addr_stable", dmem_addr1, pa);
                        check("dmem_wdata_stable", dmem_wdata1, pw);
                        check("dmem_we_stable", 32'(dmem_we1), 32'(pwe));
                    end
                    pa = dmem_addr1; pw = dmem_wdata1; pwe = dmem_we1;
                end
                prev_dreq = dmem_req1;
                if (retire1) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        check("latency", 32'(cyc - start + 1), 32'(cur.lat));
                        pend = 1;
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset1(input string tag);
        check({tag, "_out"}, out1, 32'd0);
        check({tag, "_instret"}, instret1, 32'd0);
        check({tag, "_retire"}, 32'(retire1), 32'd0);
        check({tag, "_fault"}, 32'(fault1), 32'd0);
        check({tag, "_imem_req"}, 32'(imem_req1), 32'd0);
        check({tag, "_dmem_req"}, 32'(dmem_req1), 32'd0);
        check({tag, "_pc"}, imem_addr1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqc, retc, busy;
        bit seen;
        rst = 1'b1; rst2 = 1'b1; ready2_en = 1'b0;
        load_word = 32'h1234_5678; imem_wait = 0; dmem_wait = 3; imem_limit = 32'd68;
        for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'h0050_0093;  // addi x1,x0,5
        imem[1]  = 32'h0010_2023;  // sw x1,0(x0)
        imem[2]  = 32'h0000_0463;  // beq x0,x0,+8
        imem[4]  = 32'h0000_1463;  // bne x0,x0,+8
        imem[5]  = 32'hFFD0_0193;  // addi x3,x0,-3
        imem[6]  = 32'h0040_2103;  // lw x2,4(x0)
        imem[7]  = 32'h0080_00EF;  // jal x1,+8
        imem[9]  = 32'h4031_0233;  // sub x4,x2,x3
        imem[10] = 32'hABCD_E337;  // lui x6,0xABCDE
        imem[11] = 32'h0340_0067;  // jalr x0,52(x0)
        imem[13] = 32'h0000_03B3;  // add x7,x0,x0
        imem[14] = 32'h0001_C463;  // blt x3,x0,+8
        imem[16] = 32'h0000_1417;  // auipc x8,1
        push(32'd5, 1, 32'd4, 3);
        push(32'd5, 2, 32'd8, 7);
        push(32'd5, 3, 32'd16, 3);
        push(32'd5, 4, 32'd20, 3);
        push(32'hFFFF_FFFD, 5, 32'd24, 3);
        push(32'h1234_5678, 6, 32'd28, 7);
        push(32'd32, 7, 32'd36, 3);
        push(32'h1234_567B, 8, 32'd40, 3);
        push(32'hABCD_E000, 9, 32'd44, 3);
        push(32'd48, 10, 32'd52, 3);
        push(32'd0, 11, 32'd56, 3);
        push(32'd0, 12, 32'd64, 3);
        push(32'h0000_1040, 13, 32'd68, 3);
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_reset1("rst");
        rst = 1'b0;
        wait_drain(400);
        check("dmem_writes", 32'(dmem_writes), 32'd1);
        check("dmem0", dmem[0], 32'd5);
        check("dreq_cycles", 32'(dreq_cycles), 32'd8);

        // Reset in the middle of a load handshake.
        @(negedge clk);
        rst = 1'b1; load_word = 32'hCAFE_F00D; dmem_wait = 20; imem_limit = 32'd8;
        imem[0] = 32'h0050_0093;  // addi x1,x0,5
        imem[1] = 32'h0040_2103;  // lw x2,4(x0)
        push(32'd5, 1, 32'd4, 3);
        @(negedge clk);
        rst = 1'b0;
        busy = 0;
        while (!dmem_req1 && busy < 50) begin
            @(negedge clk);
            busy++;
        end
        check("load_mem_reached", 32'(dmem_req1), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset1("midmem");
        check("sb_empty_b", 32'(sb.size()), 32'd0);
        imem[0] = 32'h0001_04B3;  // add x9,x2,x0 : x2 must still hold the old load
        dmem_wait = 0; imem_limit = 32'd4;
        push(32'h1234_5678, 1, 32'd4, 3);
        rst = 1'b0;
        wait_drain(100);

        // Timeout on a fetch that never completes.
        @(negedge clk);
        rst2 = 1'b0;
        reqc = 0;
        for (int i = 0; i < 30 && !fault2; i++) begin
            @(negedge clk);
            if (imem_req2) reqc++;
        end
        check("to_fault", 32'(fault2), 32'd1);
        check("to_req_cycles", 32'(reqc), 32'd4);
        check("to_req_dropped", 32'(imem_req2), 32'd0);
        retc = 0; busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (retire2) retc++;
            if (imem_req2) busy++;
        end
        check("fault_no_retire", 32'(retc), 32'd0);
        check("fault_no_req", 32'(busy), 32'd0);
        check("fault_sticky", 32'(fault2), 32'd1);
        rst2 = 1'b1;
        @(negedge clk);
        check("rst2_fault", 32'(fault2), 32'd0);
        check("rst2_pc", imem_addr2, 32'd0);
        check("rst2_instret", instret2, 32'd0);

        // Ready arriving in the same cycle as the timeout must win.
        ready2_en = 1'b1;
        rst2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (retire2) seen = 1;
        end
        check("tie_retire_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("tie_fault", 32'(fault2), 32'd0);
        check("tie_out", out2, 32'd5);
        check("tie_instret", instret2, 32'd1);
        check("tie_next_pc", imem_addr2, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_v_cpu_multicycle.md
Name: risc_v_cpu_multicycle

Overview:
Multi-cycle successor to the single-cycle core. It reuses decoder, registers_bank, alu, mux2_1 and mux4_1. Instruction and data memories are external, each behind a req/ready handshake, so wait-state memories are supported. A parametrised FSM sequences every instruction, adds a bus-timeout fault and counts retired instructions.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset and selected by pc_sel=3
TIMEOUT_CYCLES, 0, maximum wait cycles for a ready on either bus; 0 disables the timeout
CNT_WIDTH, 32, width of the instret counter

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (current PC)
imem_ready  in  1  fetch complete; imem_rdata is valid in this cycle
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  data address (ALU result)
dmem_wdata  out  32  store data (register operand B)
dmem_ready  in  1  data access complete; dmem_rdata is valid for loads
dmem_rdata  in  32  load data
out  out  32  last value written to the register file
retire  out  1  one-cycle pulse per retired instruction
instret  out  CNT_WIDTH  retired-instruction count; wraps modulo 2^CNT_WIDTH
fault  out  1  sticky bus-timeout flag

Behaviour:
- Reset values: state=FETCH, PC=RESET_ADDR, IR=0, out=0, instret=0, retire=0, fault=0, imem_req=0, dmem_req=0, wait counter=0.
- Reset forces these values from any state, including mid-handshake. There is no register-file write and no data-memory write in the reset cycle. The request signals drop at the next edge.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - When imem_ready=1: latch imem_rdata into IR and go to EXEC.
- EXEC (exactly 1 cycle):
  - Decoder and ALU operate on IR.
  - Latch ALU result A, operand B and the next PC.
  - pc_sel = pc_is_branch for non-branches. For branches, pc_sel = {alu[1], alu[0] XOR alu_not}.
  - Next PC by pc_sel: 0 → PC+4; 1 → PC+imm; 2 → alu (jalr); 3 → RESET_ADDR.
  - Next state is MEM if mem_we=1 or reg_sel_data_in=1 (load); otherwise WB.
- MEM:
  - dmem_req=1; dmem_we=mem_we; dmem_addr=latched A; dmem_wdata=latched B.
  - All dmem outputs stay constant while dmem_req=1.
  - When dmem_ready=1: latch dmem_rdata, deassert the request at the next edge and go to WB.
  - A store performs exactly one memory write regardless of wait length.
- WB (1 cycle):
  - Register write occurs only here, and only when reg_we=1.
  - Write data by reg_sel_data_in: 0 → ALU result; 1 → load data; 2 → PC+4; 3 → PC+ALU result.
  - out updates to the written value when reg_we=1 and is unchanged otherwise.
  - PC ← next PC; retire=1; instret+1; go to FETCH.
  - x0 is never modified (register bank rule); out still shows the value that was presented.
- Latency with zero-wait memory (ready in the first request cycle):
  - ALU, branch and jump instructions: 3 cycles.
  - Loads and stores: 4 cycles.
  - Each wait cycle adds 1.
- Timeout (TIMEOUT_CYCLES>0):
  - The wait counter counts request cycles with ready=0 and clears when a handshake completes.
  - When it reaches TIMEOUT_CYCLES: fault=1, the request is dropped and the state goes to FAULT.
- FAULT: terminal state; no requests, no retire; only reset exits it.
- A ready that is asserted while no request is outstanding is ignored.
- Simultaneous ready and timeout in the same cycle: ready wins.

Test Plan:
- addi x1,x0,5 (0x00500093) at PC 0, both readies tied to 1 → retire in cycle 3, out=5, instret=1, imem_addr=4 in the next FETCH.
- sw x1,0(x0) after the addi, dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with addr=0 and wdata=5 stable, exactly one write, retire at cycle 7 of the instruction.
- beq x0,x0,+8 at PC 8 → next imem_addr=16. bne x0,x0,+8 at PC 8 → next imem_addr=12.
- jal x1,+8 at PC 4 → out=8, next imem_addr=12.
- TIMEOUT_CYCLES=4, imem_ready held at 0 → fault=1 after 4 request cycles, imem_req=0, no further retire until reset; after reset, fault=0 and imem_addr=RESET_ADDR.
- Reset asserted during MEM of a load → no register write, dmem_req=0 at the next edge, PC=RESET_ADDR, instret=0.
